// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the Hi/Lo register pair: radix-2 shift-add multiply,
// restoring divide, one operand bit per cycle under a start/busy/done handshake.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             is_sgn_q, is_sgn_d;
    logic             sign_q, sign_d;
    logic             rsign_q, rsign_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;

    logic             op_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Operand magnitudes and per-iteration datapath
    always_comb begin
        op_sgn   = ~op[0];
        a_mag    = (op_sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag    = (op_sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        div_sh   = acc_q[W2-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, opb_q});
        div_sub  = WIDTH'(div_sh - {1'b0, opb_q});
        div_rem  = div_ge ? div_sub : div_sh[WIDTH-1:0];
        prod_fix = (is_sgn_q && sign_q) ? (~acc_q + W2'(1)) : acc_q;
        quot_fix = (is_sgn_q && sign_q) ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_fix  = (is_sgn_q && rsign_q) ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (op[1] && (b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d = op[1];
                        is_sgn_d = op_sgn;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        rsign_d  = a[WIDTH-1];
                        if (op[1]) begin
                            acc_d = {WIDTH'(0), a_mag};
                            opb_d = b_mag;
                        end else begin
                            acc_d = {WIDTH'(0), b_mag};
                            opb_d = a_mag;
                        end
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
